// File: rtl/iir_sched.sv
// rtl/iir_sched.sv - sample-rate scheduler sequencing one shared MAC over LP then HP biquad taps
// Optional feature macro: IIR_SCHED_OVERRUN_EN (sticky overrun flag; tied to 0 when undefined)
module iir_sched #(
  parameter int CLK_DIV = 64,
  parameter int TAPS    = 5,
  parameter int TW      = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          filter_rst,
  input  logic          mac_ready,
  output logic          sample_tick,
  output logic          ch_sel,
  output logic [TW-1:0] tap_idx,
  output logic          mac_clr,
  output logic          mac_valid,
  output logic          acc_latch,
  output logic          state_clr,
  output logic          overrun
);

  localparam int DW = $clog2(CLK_DIV);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLR   = 2'd1;
  localparam logic [1:0] S_TAP   = 2'd2;
  localparam logic [1:0] S_LATCH = 2'd3;

  // A full two-channel sequence must fit inside one sample period.
  if (CLK_DIV < 2 * (TAPS + 2) + 1) begin : g_bad_clk_div
    $error("iir_sched: CLK_DIV must be >= 2*(TAPS+2)+1");
  end
  if ((1 << TW) < TAPS) begin : g_bad_tw
    $error("iir_sched: TW too narrow to index TAPS");
  end

  logic [DW-1:0] r_div_cnt;
  logic [1:0]    r_state;
  logic          r_ch_sel;
  logic [TW-1:0] r_tap_idx;
  logic          r_state_clr;
  logic          w_tick;
  logic          w_last_tap;

  assign w_tick     = (r_div_cnt == DW'(CLK_DIV - 1));
  assign w_last_tap = (r_tap_idx == TW'(TAPS - 1));

  // Free-running sample divider; keeps counting through filter_rst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div_cnt <= '0;
    end else if (w_tick) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + DW'(1);
    end
  end

  // Sequencer: CLR -> TAP x TAPS -> LATCH for low-pass, then the same for high-pass.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_ch_sel  <= 1'b0;
      r_tap_idx <= '0;
    end else if (filter_rst) begin
      r_state   <= S_IDLE;
      r_ch_sel  <= 1'b0;
      r_tap_idx <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_tick) begin
            r_state   <= S_CLR;
            r_ch_sel  <= 1'b0;
            r_tap_idx <= '0;
          end
        end
        S_CLR: begin
          r_state   <= S_TAP;
          r_tap_idx <= '0;
        end
        S_TAP: begin
          // Index only moves on a completed handshake so the MAC sees a stable operand.
          if (mac_ready) begin
            if (w_last_tap) begin
              r_state <= S_LATCH;
            end else begin
              r_tap_idx <= r_tap_idx + TW'(1);
            end
          end
        end
        default: begin
          r_tap_idx <= '0;
          if (!r_ch_sel) begin
            r_ch_sel <= 1'b1;
            r_state  <= S_CLR;
          end else begin
            r_ch_sel <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
      endcase
    end
  end

  // Delay-line clear follows the filter hold one cycle later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state_clr <= 1'b0;
    end else begin
      r_state_clr <= filter_rst;
    end
  end

`ifdef IIR_SCHED_OVERRUN_EN
  logic r_overrun;

  // Sticky flag: a tick landed while a sequence was still busy and was dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overrun <= 1'b0;
    end else if (w_tick && (r_state != S_IDLE)) begin
      r_overrun <= 1'b1;
    end
  end

  assign overrun = r_overrun;
`else
  assign overrun = 1'b0;
`endif

  // Strobes are gated by filter_rst in the same cycle so the MAC sees nothing once the hold begins.
  assign sample_tick = w_tick;
  assign ch_sel      = r_ch_sel;
  assign tap_idx     = r_tap_idx;
  assign mac_clr     = (r_state == S_CLR)   && !filter_rst;
  assign mac_valid   = (r_state == S_TAP)   && !filter_rst;
  assign acc_latch   = (r_state == S_LATCH) && !filter_rst;
  assign state_clr   = r_state_clr;

endmodule

// File: tb/tb_iir_sched.sv
// tb/tb_iir_sched.sv - self-checking bench for iir_sched against a step-list reference model
module tb_iir_sched;

  localparam int TAPS = 5;
  localparam int TW   = 3;
  localparam int HALF = TAPS + 2;
`ifdef IIR_SCHED_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  logic filter_rst;
  logic mac_ready;

  logic a_tick, a_ch, a_clr, a_valid, a_latch, a_sclr, a_ovr;
  logic [TW-1:0] a_tap;
  logic b_tick, b_ch, b_clr, b_valid, b_latch, b_sclr, b_ovr;
  logic [TW-1:0] b_tap;

  int checks;
  int failures;

  int m_cnt[2];
  int m_pos[2];
  bit m_frd[2];
  bit m_ovr[2];
  int cdiv[2];

  logic obs_tick, obs_clr, obs_valid, obs_latch, obs_ch, obs_sclr;
  logic [TW-1:0] obs_tap;
  logic obs_b_tick, obs_b_clr, obs_b_latch, obs_b_ovr;

  iir_sched #(.CLK_DIV(64), .TAPS(TAPS), .TW(TW)) dut (
    .clk(clk), .rst(rst), .filter_rst(filter_rst), .mac_ready(mac_ready),
    .sample_tick(a_tick), .ch_sel(a_ch), .tap_idx(a_tap), .mac_clr(a_clr),
    .mac_valid(a_valid), .acc_latch(a_latch), .state_clr(a_sclr), .overrun(a_ovr)
  );

  iir_sched #(.CLK_DIV(16), .TAPS(TAPS), .TW(TW)) dut16 (
    .clk(clk), .rst(rst), .filter_rst(filter_rst), .mac_ready(mac_ready),
    .sample_tick(b_tick), .ch_sel(b_ch), .tap_idx(b_tap), .mac_clr(b_clr),
    .mac_valid(b_valid), .acc_latch(b_latch), .state_clr(b_sclr), .overrun(b_ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string name, input int inst, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d t=%0t got=%b exp=%b", name, inst, $time, got, exp);
    end
  endtask

  // One cycle: compare both instances against the model at negedge, then advance the model.
  task automatic step();
    logic o_tick, o_ch, o_clr, o_valid, o_latch, o_sclr, o_ovr;
    logic [TW-1:0] o_tap;
    logic e_clr, e_valid, e_latch, e_tick, e_ch;
    logic [TW-1:0] e_tap;
    int p, k;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        m_cnt[i] = 0; m_pos[i] = -1; m_frd[i] = 1'b0; m_ovr[i] = 1'b0;
      end
      o_tick  = (i == 0) ? a_tick  : b_tick;
      o_ch    = (i == 0) ? a_ch    : b_ch;
      o_clr   = (i == 0) ? a_clr   : b_clr;
      o_valid = (i == 0) ? a_valid : b_valid;
      o_latch = (i == 0) ? a_latch : b_latch;
      o_sclr  = (i == 0) ? a_sclr  : b_sclr;
      o_ovr   = (i == 0) ? a_ovr   : b_ovr;
      o_tap   = (i == 0) ? a_tap   : b_tap;
      p = m_pos[i];
      k = (p >= 0) ? (p % HALF) : 0;
      e_tick  = rst && (m_cnt[i] == cdiv[i] - 1);
      e_clr   = rst && !filter_rst && (p >= 0) && (k == 0);
      e_latch = rst && !filter_rst && (p >= 0) && (k == TAPS + 1);
      e_valid = rst && !filter_rst && (p >= 0) && (k >= 1) && (k <= TAPS);
      e_ch    = (p >= HALF);
      e_tap   = (k == 0) ? '0 : TW'(k - 1);
      chk1("sample_tick", i, o_tick, e_tick);
      chk1("mac_clr", i, o_clr, e_clr);
      chk1("mac_valid", i, o_valid, e_valid);
      chk1("acc_latch", i, o_latch, e_latch);
      chk1("state_clr", i, o_sclr, m_frd[i]);
      chk1("overrun", i, o_ovr, m_ovr[i]);
      if (!rst) begin
        chk1("ch_sel_rst", i, o_ch, 1'b0);
        checks++;
        if (o_tap !== '0) begin
          failures++;
          $display("FAIL tap_idx_rst inst=%0d t=%0t got=%0d exp=0", i, $time, o_tap);
        end
      end else if (p >= 0) begin
        chk1("ch_sel", i, o_ch, e_ch);
        if (k <= TAPS) begin
          checks++;
          if (o_tap !== e_tap) begin
            failures++;
            $display("FAIL tap_idx inst=%0d t=%0t got=%0d exp=%0d", i, $time, o_tap, e_tap);
          end
        end
      end
      if (rst) begin
        if (e_tick && p >= 0 && OVR_EN) m_ovr[i] = 1'b1;
        if (filter_rst) m_pos[i] = -1;
        else if (p < 0) begin
          if (e_tick) m_pos[i] = 0;
        end else if (!(k >= 1 && k <= TAPS && !mac_ready)) begin
          m_pos[i] = (p + 1 == 2 * HALF) ? -1 : p + 1;
        end
        m_cnt[i] = (m_cnt[i] + 1) % cdiv[i];
        m_frd[i] = filter_rst;
      end
    end
    obs_tick = a_tick; obs_clr = a_clr; obs_valid = a_valid; obs_latch = a_latch;
    obs_ch = a_ch; obs_sclr = a_sclr; obs_tap = a_tap;
    obs_b_tick = b_tick; obs_b_clr = b_clr; obs_b_latch = b_latch; obs_b_ovr = b_ovr;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick(input bit inst_b);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      step();
      seen = inst_b ? obs_b_tick : obs_tick;
    end
    chk1("tick_timeout", inst_b, seen, 1'b1);
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b0; filter_rst = 1'b0; mac_ready = 1'b1;
    repeat (3) step();
    chk1("reset_outputs", 0, obs_tick | obs_clr | obs_valid | obs_latch | obs_ch | obs_sclr | (|obs_tap), 1'b0);
    rst = 1'b1;
    n = 0;
    for (int j = 0; j < 200; j++) begin
      step();
      if (obs_tick) break;
      n++;
    end
    checks++;
    if (n != 63) begin
      failures++;
      $display("FAIL first_tick_latency got=%0d exp=63", n);
    end
  endtask

  task automatic test_nominal();
    int taps[$];
    bit ok;
    mac_ready = 1'b1;
    wait_tick(1'b0);
    for (int j = 1; j <= 15; j++) begin
      step();
      chk1("nom_clr", j, obs_clr, (j == 1 || j == 8));
      chk1("nom_latch", j, obs_latch, (j == 7 || j == 14));
      if (obs_latch) chk1("nom_latch_ch", j, obs_ch, (j == 14));
      if (obs_valid) taps.push_back(int'(obs_tap));
    end
    ok = (taps.size() == 2 * TAPS);
    for (int j = 0; j < taps.size() && ok; j++) if (taps[j] != j % TAPS) ok = 1'b0;
    chk1("nom_tap_sequence", 0, ok, 1'b1);
  endtask

  task automatic test_backpressure();
    int latches[$];
    wait_tick(1'b0);
    for (int j = 1; j <= 20; j++) begin
      mac_ready = !(j >= 4 && j <= 7);
      step();
      if (j >= 4 && j <= 7) begin
        chk1("bp_valid_held", j, obs_valid, 1'b1);
        chk1("bp_tap_held", j, obs_tap == TW'(2), 1'b1);
      end
      if (obs_latch) latches.push_back(j);
    end
    mac_ready = 1'b1;
    checks++;
    if (latches.size() != 2 || latches[0] != 11 || latches[1] != 18) begin
      failures++;
      $display("FAIL bp_latch_times got_count=%0d exp=11,18", latches.size());
    end
  endtask

  task automatic test_overrun();
    int nlatch, nclr;
    mac_ready = 1'b1;
    wait_tick(1'b1);
    nlatch = 0; nclr = 0;
    for (int j = 1; j <= 40; j++) begin
      mac_ready = (j > 20);
      step();
      if (j >= 2 && j <= 26 && obs_b_clr) nclr++;
      if (j > 20 && obs_b_latch) nlatch++;
      if (j == 17) chk1("ovr_set", 1, obs_b_ovr, OVR_EN);
    end
    chk1("ovr_sticky", 1, obs_b_ovr, OVR_EN);
    checks++;
    if (nclr != 0) begin
      failures++;
      $display("FAIL ovr_dropped_tick_clr got=%0d exp=0", nclr);
    end
    checks++;
    if (nlatch != 2) begin
      failures++;
      $display("FAIL ovr_completion_latches got=%0d exp=2", nlatch);
    end
  endtask

  task automatic test_filter_rst();
    int act;
    mac_ready = 1'b1;
    wait_tick(1'b0);
    for (int j = 1; j <= 9; j++) step();
    filter_rst = 1'b1;
    step();
    chk1("frst_valid_same_cycle", 0, obs_valid, 1'b0);
    act = 0;
    for (int j = 0; j < 80; j++) begin
      step();
      if (j == 0) chk1("frst_state_clr", 0, obs_sclr, 1'b1);
      if (obs_latch | obs_clr | obs_valid) act++;
    end
    checks++;
    if (act != 0) begin
      failures++;
      $display("FAIL frst_activity got=%0d exp=0", act);
    end
    filter_rst = 1'b0;
    wait_tick(1'b0);
    step();
    chk1("frst_resume_clr", 0, obs_clr, 1'b1);
  endtask

  task automatic test_random();
    int fr_left;
    fr_left = 0;
    for (int j = 0; j < 3000; j++) begin
      mac_ready = ($urandom_range(0, 3) != 0);
      if (fr_left > 0) fr_left--;
      else if ($urandom_range(0, 299) == 0) fr_left = $urandom_range(1, 6);
      filter_rst = (fr_left > 0);
      rst = !(j == 1500 || j == 1501);
      step();
    end
    rst = 1'b1; filter_rst = 1'b0; mac_ready = 1'b1;
  endtask

  initial begin
    checks = 0; failures = 0;
    cdiv[0] = 64; cdiv[1] = 16;
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_pos[i] = -1; m_frd[i] = 1'b0; m_ovr[i] = 1'b0;
    end
    rst = 1'b0; filter_rst = 1'b0; mac_ready = 1'b1;
    test_reset();
    test_nominal();
    test_backpressure();
    test_overrun();
    test_filter_rst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
